game_link_tx: RTL and testbench
===============================

Name: game_link_tx

Overview:
- Transmit side of the board-to-board game link; the peer board's receiver decodes these packets into its game-state selector.
- Snapshots local game mode, player role, collision flag and player head position, frames them as a fixed packet, and serialises it as 8N1 UART on a single `tx` line.
- Sits beside `gamemode_control`, driven by a frame-rate request pulse.

Parameters:
- CLK_DIV, 564, clock cycles per UART bit; legal range >= 2.
- HEADER, 8'hA5, first byte of every packet.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- send_req  input  1  single-cycle packet request
- mode  input  2  game_mode from game_pkg: START=0, GAME=1, PLAYER1_WIN=2, PLAYER2_WIN=3
- player1  input  1  local board is player 1
- player2  input  1  local board is player 2
- collision  input  1  local player collided
- xpos  input  12  local head X
- ypos  input  12  local head Y
- tx  output  1  UART serial out, idle high
- busy  output  1  packet in progress
- pkt_done  output  1  one-cycle pulse at end of packet

Behaviour:
- One clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - tx=1, busy=0, pkt_done=0.
  - Pending flag=0, sequence counter seq[2:0]=0, FSM=IDLE.
- Reset mid-packet aborts immediately. tx=1 from the next edge; no partial byte is completed.
- Packet byte order:
  - B0=HEADER.
  - B1={mode[1:0], player1, player2, collision, seq[2:0]}.
  - B2=xpos[7:0].
  - B3={xpos[11:8], ypos[11:8]}.
  - B4=ypos[7:0].
- Snapshot: all inputs are registered on the cycle the packet starts (IDLE->START_BIT). Input changes during the packet do not affect it.
- Each byte is framed as start(0), D0..D7 LSB first, stop(1).
  - Every bit lasts exactly CLK_DIV cycles.
  - Bytes are back-to-back with no idle gap.
  - Packet length = 5*10*CLK_DIV cycles.
- FSM states and transitions:
  - IDLE: tx=1. Enter START_BIT when send_req=1 or pending=1.
  - START_BIT: tx=0 for CLK_DIV cycles, then DATA_BITS.
  - DATA_BITS: bit index 0..7, CLK_DIV cycles each, then STOP_BIT.
  - STOP_BIT: tx=1 for CLK_DIV cycles. Then START_BIT of the next byte, or IDLE after the last byte.
- Latency: tx falls on the first cycle after the edge that samples send_req in IDLE; busy rises on that same cycle.
- busy is 1 in every state except IDLE.
- pkt_done pulses 1 on the cycle the FSM returns to IDLE. busy=0 in that cycle. seq increments in that cycle and wraps 7->0.
- Requests while busy=1 set pending. Any number of such requests collapse into one packet.
- send_req coincident with pkt_done counts as pending.
- If pending=1 on entering IDLE: the next packet's start bit begins on the following cycle, pending clears, and a fresh snapshot is taken.
- Baud counter is 16-bit or wider and unsigned. It is reset to 0 at every bit boundary, so there is no drift.

Optional Feature:
- GAME_LINK_CHECKSUM_EN defined:
  - A sixth byte B5 = B1^B2^B3^B4 is sent after B4.
  - Packet length becomes 6*10*CLK_DIV cycles.
  - pkt_done follows the B5 stop bit.
- GAME_LINK_CHECKSUM_EN not defined: 5-byte packet, no checksum logic present.

Test Plan (all scenarios with CLK_DIV=4):
- Basic packet: reset, then send_req with mode=1, player1=1, player2=0, collision=0, xpos=12'h123, ypos=12'h2AB.
  - Decoded bytes are A5,60,23,12,AB.
  - busy is high for exactly 200 cycles, then pkt_done pulses once; with the macro, B5=FA and 240 cycles.
- Snapshot and seq: change xpos/mode mid-packet, then issue a second send_req after done.
  - First packet is unchanged.
  - Second packet B1 carries seq=1 and the new values.
  - After 8 packets, seq has wrapped to 0.
- Collapse: three send_req pulses during a busy packet, one of them coincident with pkt_done.
  - Exactly one further packet, starting the cycle after pkt_done.
  - Then idle, tx=1.
- Bit timing: every tx level holds a multiple of 4 cycles.
  - The start bit begins 1 cycle after the send_req edge.
  - There is no idle gap between B0 stop and B1 start.
- Reset mid-packet: assert rst during B2 data bits.
  - Next cycle tx=1, busy=0, pkt_done=0.
  - The next packet has seq=0 and starts with A5.
- Win state: mode=3, player2=1, collision=1, xpos=0, ypos=12'hFFF.
  - B1=D8, B2=00, B3=0F, B4=FF.

Source files
------------

// File: rtl/game_link_tx.sv
// game_link_tx: snapshots game state and sends it as an 8N1 UART packet; optional XOR checksum byte via GAME_LINK_CHECKSUM_EN.
// Latency: start bit on tx the cycle after send_req is sampled in IDLE; packet lasts NBYTES*10*CLK_DIV cycles.
// Backpressure: requests while busy collapse into one pending packet, started the cycle after pkt_done.
module game_link_tx #(
  parameter int         CLK_DIV = 564,
  parameter logic [7:0] HEADER  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_req,
  input  logic [1:0]  mode,
  input  logic        player1,
  input  logic        player2,
  input  logic        collision,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic        tx,
  output logic        busy,
  output logic        pkt_done
);

  localparam int            CW        = ($clog2(CLK_DIV) > 16) ? $clog2(CLK_DIV) : 16;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
`ifdef GAME_LINK_CHECKSUM_EN
  localparam logic [2:0]    LAST_BYTE = 3'd5;
`else
  localparam logic [2:0]    LAST_BYTE = 3'd4;
`endif

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [2:0]    seq;
  logic [7:0]    shift;
  logic [7:0]    b1, b2, b3, b4;
  logic [7:0]    next_byte;
  logic          pending;
  logic          baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);

  // Byte that follows the one currently on the wire.
  always_comb begin
    next_byte = HEADER;
    case (byte_idx)
      3'd0:    next_byte = b1;
      3'd1:    next_byte = b2;
      3'd2:    next_byte = b3;
      3'd3:    next_byte = b4;
`ifdef GAME_LINK_CHECKSUM_EN
      3'd4:    next_byte = b1 ^ b2 ^ b3 ^ b4;
`endif
      default: next_byte = HEADER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      pkt_done <= 1'b0;
      pending  <= 1'b0;
      seq      <= 3'd0;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 3'd0;
      shift    <= 8'd0;
      b1       <= 8'd0;
      b2       <= 8'd0;
      b3       <= 8'd0;
      b4       <= 8'd0;
    end else begin
      pkt_done <= 1'b0;
      if (state != IDLE && send_req) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (send_req || pending) begin
            state    <= START_BIT;
            tx       <= 1'b0;
            busy     <= 1'b1;
            pending  <= 1'b0;
            baud_cnt <= '0;
            byte_idx <= 3'd0;
            bit_idx  <= 3'd0;
            shift    <= HEADER;
            b1       <= {mode, player1, player2, collision, seq};
            b2       <= xpos[7:0];
            b3       <= {xpos[11:8], ypos[11:8]};
            b4       <= ypos[7:0];
          end
        end
        START_BIT: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= DATA_BITS;
            bit_idx  <= 3'd0;
            tx       <= shift[0];
            shift    <= {1'b0, shift[7:1]};
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA_BITS: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP_BIT;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP_BIT: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              state    <= IDLE;
              tx       <= 1'b1;
              busy     <= 1'b0;
              pkt_done <= 1'b1;
              seq      <= seq + 3'd1;
            end else begin
              state    <= START_BIT;
              tx       <= 1'b0;
              byte_idx <= byte_idx + 3'd1;
              shift    <= next_byte;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_link_tx.sv
// Bench for game_link_tx at CLK_DIV=4: per-cycle reference model plus decoded-packet literal checks.
module tb_game_link_tx;
  localparam int CD = 4;
`ifdef GAME_LINK_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int PLEN = NB * 10 * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send_req = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        player1 = 1'b0;
  logic        player2 = 1'b0;
  logic        collision = 1'b0;
  logic [11:0] xpos = 12'd0;
  logic [11:0] ypos = 12'd0;
  logic        tx, busy, pkt_done;

  game_link_tx #(.CLK_DIV(CD), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .send_req(send_req), .mode(mode),
    .player1(player1), .player2(player2), .collision(collision),
    .xpos(xpos), .ypos(ypos), .tx(tx), .busy(busy), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet is a precomputed list of bit levels, each held CD cycles.
  bit         m_active = 1'b0;
  bit         m_pend = 1'b0;
  bit         m_done = 1'b0;
  int         m_pos = 0;
  int         m_seq = 0;
  logic [7:0] m_by [0:5];
  logic       m_bits [0:59];

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_active = 1'b0; m_pend = 1'b0; m_pos = 0; m_seq = 0;
    end else if (m_active) begin
      if (send_req) m_pend = 1'b1;
      m_pos++;
      if (m_pos == PLEN) begin
        m_active = 1'b0; m_done = 1'b1; m_seq = (m_seq + 1) % 8;
      end
    end else if (send_req || m_pend) begin
      m_by[0] = 8'hA5;
      m_by[1] = {mode, player1, player2, collision, 3'(m_seq)};
      m_by[2] = xpos[7:0];
      m_by[3] = {xpos[11:8], ypos[11:8]};
      m_by[4] = ypos[7:0];
      m_by[5] = m_by[1] ^ m_by[2] ^ m_by[3] ^ m_by[4];
      for (int i = 0; i < NB; i++) begin
        m_bits[i*10] = 1'b0;
        for (int j = 0; j < 8; j++) m_bits[i*10+1+j] = m_by[i][j];
        m_bits[i*10+9] = 1'b1;
      end
      m_active = 1'b1; m_pos = 0; m_pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx", {31'd0, tx}, {31'd0, (m_active ? m_bits[m_pos / CD] : 1'b1)});
      chk("busy", {31'd0, busy}, {31'd0, m_active});
      chk("pkt_done", {31'd0, pkt_done}, {31'd0, m_done});
    end
  end

  // Recorder: captures tx while busy and decodes complete packets by mid-bit sampling.
  logic        rec [$];
  logic [47:0] pkts [$];
  int          lens [$];
  int          done_cnt = 0;
  logic [47:0] rp;

  always @(negedge clk) begin
    if (rst) begin
      rec.delete();
    end else if (busy) begin
      rec.push_back(tx);
    end else if (rec.size() > 0) begin
      rp = '0;
      lens.push_back(rec.size());
      if (rec.size() == PLEN)
        for (int i = 0; i < NB; i++)
          for (int j = 0; j < 8; j++) rp[i*8+j] = rec[(i*10+1+j)*CD + CD/2];
      pkts.push_back(rp);
      rec.delete();
    end
    if (pkt_done) done_cnt++;
  end

  task automatic pulse();
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
  endtask

  task automatic do_send();
    pulse();
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_tx", {31'd0, tx}, 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!pkt_done && n < 3 * PLEN) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", {31'd0, pkt_done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_pkt(string name, logic [47:0] exp);
    logic [47:0] p;
    int l;
    p = (pkts.size() > 0) ? pkts[pkts.size()-1] : '0;
    l = (lens.size() > 0) ? lens[lens.size()-1] : 0;
    chk({name, "_len"}, l, PLEN);
    for (int i = 0; i < NB; i++)
      chk($sformatf("%s_b%0d", name, i), {24'd0, p[i*8 +: 8]}, {24'd0, exp[i*8 +: 8]});
  endtask

  task automatic rand_inputs();
    mode = 2'($urandom_range(0, 3));
    player1 = 1'($urandom_range(0, 1));
    player2 = 1'($urandom_range(0, 1));
    collision = 1'($urandom_range(0, 1));
    xpos = 12'($urandom);
    ypos = 12'($urandom);
  endtask

  initial begin
    logic [47:0] lastp;
    int c0;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, pkt_done}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Basic packet, inputs changed mid-packet must not leak in.
    mode = 2'd1; player1 = 1'b1; player2 = 1'b0; collision = 1'b0;
    xpos = 12'h123; ypos = 12'h2AB;
    do_send();
    chk("model_b1", {24'd0, m_by[1]}, 32'h60);
    chk("model_b3", {24'd0, m_by[3]}, 32'h12);
    repeat (60) @(negedge clk);
    mode = 2'd2; xpos = 12'h456;
    wait_done();
    check_pkt("basic", {8'hFA, 8'hAB, 8'h12, 8'h23, 8'h60, 8'hA5});

    // Second packet carries seq=1 and the new values.
    do_send();
    wait_done();
    check_pkt("seq1", {8'h1E, 8'hAB, 8'h42, 8'h56, 8'hA1, 8'hA5});

    // Packets 3..8 with random contents, then the 9th must show seq wrapped to 0.
    for (int k = 0; k < 6; k++) begin
      rand_inputs();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_send();
      wait_done();
    end
    rand_inputs();
    do_send();
    wait_done();
    lastp = (pkts.size() > 0) ? pkts[pkts.size()-1] : 48'hFFFF_FFFF_FFFF;
    chk("seq_wrap", {29'd0, lastp[10:8]}, 32'd0);

    // Collapse: three requests while busy, the last coincident with pkt_done.
    c0 = done_cnt;
    rand_inputs();
    do_send();
    repeat (30) @(negedge clk);
    rand_inputs();
    pulse();
    repeat (40) @(negedge clk);
    pulse();
    n = 0;
    while (!pkt_done && n < 3 * PLEN) begin
      @(negedge clk);
      n++;
    end
    chk("collapse_done_seen", {31'd0, pkt_done}, 32'd1);
    pulse();
    chk("collapse_restart", {31'd0, busy}, 32'd1);
    wait_done();
    repeat (20) @(negedge clk);
    chk("collapse_idle_busy", {31'd0, busy}, 32'd0);
    chk("collapse_idle_tx", {31'd0, tx}, 32'd1);
    chk("collapse_count", done_cnt, c0 + 2);

    // Reset during B2 data bits.
    rand_inputs();
    do_send();
    repeat (90) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, pkt_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Win state right after reset: seq restarts at 0.
    mode = 2'd3; player1 = 1'b0; player2 = 1'b1; collision = 1'b1;
    xpos = 12'h000; ypos = 12'hFFF;
    do_send();
    wait_done();
    check_pkt("win", {8'h28, 8'hFF, 8'h0F, 8'h00, 8'hD8, 8'hA5});

    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
